// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer on the data-memory bus: one-shot or
// auto-reload periods, programmable prescaler, sticky expiry flag and level irq.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0200,
  parameter int          PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_LOAD   = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  logic                  en_reg, en_next;
  logic                  auto_reg, auto_next;
  logic                  irq_en_reg, irq_en_next;
  logic [PRESCALE_W-1:0] prescale_reg, prescale_next;
  logic [PRESCALE_W-1:0] pcnt_reg, pcnt_next;
  logic [31:0]           load_reg, load_next;
  logic [31:0]           count_reg, count_next;
  logic                  expired_reg, expired_next;

  logic       hit;
  logic [1:0] off;
  logic       wr_ctrl, wr_load, wr_status;
  logic       tick;
  logic       unused_addr_bits;

  assign hit              = (a[31:4] == BASE_ADDR[31:4]);
  assign off              = a[3:2];
  assign unused_addr_bits = ^a[1:0];
  assign wr_ctrl          = we && hit && (off == OFF_CTRL);
  assign wr_load          = we && hit && (off == OFF_LOAD);
  assign wr_status        = we && hit && (off == OFF_STATUS);
  assign tick             = en_reg && (pcnt_reg == prescale_reg);

  always_comb begin
    en_next       = en_reg;
    auto_next     = auto_reg;
    irq_en_next   = irq_en_reg;
    prescale_next = prescale_reg;
    load_next     = load_reg;
    count_next    = count_reg;
    expired_next  = expired_reg;
    pcnt_next     = pcnt_reg;

    // Clear first so that an expiry in the same cycle wins over W1C.
    if (wr_status && wd[0]) begin
      expired_next = 1'b0;
    end

    // A LOAD write suppresses both decrement and expiry on this edge.
    if (tick && !wr_load) begin
      if (count_reg > 32'd1) begin
        count_next = count_reg - 32'd1;
      end else begin
        expired_next = 1'b1;
        if (auto_reg) begin
          count_next = load_reg;
        end else begin
          count_next = '0;
          en_next    = 1'b0;
        end
      end
    end

    // Placed after the tick logic so a CTRL write overrides one-shot self-stop.
    if (wr_ctrl) begin
      en_next       = wd[0];
      auto_next     = wd[1];
      irq_en_next   = wd[2];
      prescale_next = wd[8 +: PRESCALE_W];
    end

    if (wr_load) begin
      load_next  = wd;
      count_next = wd;
    end

    if (!en_next || tick || wr_load || (wr_ctrl && wd[0] && !en_reg)) begin
      pcnt_next = '0;
    end else begin
      pcnt_next = pcnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_reg       <= 1'b0;
      auto_reg     <= 1'b0;
      irq_en_reg   <= 1'b0;
      prescale_reg <= '0;
      pcnt_reg     <= '0;
      load_reg     <= '0;
      count_reg    <= '0;
      expired_reg  <= 1'b0;
    end else begin
      en_reg       <= en_next;
      auto_reg     <= auto_next;
      irq_en_reg   <= irq_en_next;
      prescale_reg <= prescale_next;
      pcnt_reg     <= pcnt_next;
      load_reg     <= load_next;
      count_reg    <= count_next;
      expired_reg  <= expired_next;
    end
  end

  always_comb begin
    rd = '0;
    if (hit) begin
      case (off)
        OFF_CTRL: begin
          rd[0]                = en_reg;
          rd[1]                = auto_reg;
          rd[2]                = irq_en_reg;
          rd[8 +: PRESCALE_W]  = prescale_reg;
        end
        OFF_LOAD:   rd = load_reg;
        OFF_COUNT:  rd = count_reg;
        OFF_STATUS: rd[0] = expired_reg;
        default:    rd = '0;
      endcase
    end
  end

  assign irq = expired_reg && irq_en_reg;

endmodule
